// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector result path: image geometry
// defaults, the dump/UART state encoding and the derived pixel count.
package edge_pkg;

    // Image geometry and BRAM address width shared with the edge detector.
    localparam int IMG_H   = 500;
    localparam int IMG_V   = 500;
    localparam int BRAM_AW = 18;
    localparam int NPIX    = IMG_H * IMG_V;

    // One encoding is shared by the dump sequencer (IDLE..LOAD, plus STOP
    // while the byte is on the wire) and the serialiser (IDLE, START..STOP).
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser, LSB first, txd idles high.
// Ports: clk, rst_n (sync, active-high), tx_valid/tx_data in, tx_ready, txd out.
module uart_tx_byte
    import edge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    state_t          state;
    logic [7:0]      shreg;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic            bit_end;

    assign bit_end = (baud_cnt == LAST);

    // Ready also in the last stop-bit cycle so the next byte can follow
    // without an extra idle cycle when the producer is waiting for it.
    assign tx_ready = (state == IDLE) || ((state == STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        txd      <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (tx_valid) begin
                            shreg <= tx_data;
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/result_uart_dump.sv
// Streams the result BRAM (pixels 0..H*V-1, raster order) out over UART 8N1
// once per rising edge of start. Optional macro BINARIZE_EN thresholds bytes.
// Ports: clk, rst_n (sync, active-high), start, addrb2/doutb2 (BRAM port B,
// 1-cycle read latency), txd, busy, done (one-cycle pulse at frame end).
module result_uart_dump
    import edge_pkg::*;
#(
    parameter int          H            = IMG_H,
    parameter int          V            = IMG_V,
    parameter int          AW           = BRAM_AW,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  THRESH       = 8'd64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] addrb2,
    input  logic [7:0]    doutb2,
    output logic          txd,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(H * V - 1);

    state_t     state;
    logic       start_q;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

`ifdef BINARIZE_EN
    assign tx_data = (doutb2 >= THRESH) ? 8'hFF : 8'h00;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign tx_data       = doutb2;
`endif

    // LOAD hands the byte to the serialiser; its txd falls on that edge.
    assign tx_valid = (state == LOAD) && tx_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            addrb2  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !start_q) begin
                        addrb2 <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: state <= WAIT;
                WAIT:  state <= LOAD;
                LOAD: begin
                    if (tx_ready) begin
                        state <= STOP;
                    end
                end
                // Byte on the wire; tx_ready rises in its final stop cycle.
                STOP: begin
                    if (tx_ready) begin
                        if (addrb2 == LAST_ADDR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            addrb2 <= addrb2 + 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .txd      (txd)
    );

endmodule

// File: tb/tb_result_uart_dump.sv
// Self-checking bench for result_uart_dump: H=4, V=2, CLKS_PER_BIT=4,
// BRAM model with 1-cycle latency, per-cycle waveform reference model.
module tb_result_uart_dump;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int AW   = 3;
    localparam int CPB  = 4;
    localparam int NPIX = H * V;
    localparam int P    = 10 * CPB + 3;
    localparam logic [7:0] TH = 8'h13;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addrb2;
    logic [7:0]    doutb2;
    logic          txd;
    logic          busy;
    logic          done;

    logic [7:0] mem [0:NPIX-1];

    int n_cmp;
    int n_bad;

    result_uart_dump #(
        .H            (H),
        .V            (V),
        .AW           (AW),
        .CLKS_PER_BIT (CPB),
        .THRESH       (TH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .addrb2 (addrb2),
        .doutb2 (doutb2),
        .txd    (txd),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) doutb2 <= mem[addrb2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0] b;
        b = mem[k];
`ifdef BINARIZE_EN
        b = (b >= TH) ? 8'hFF : 8'h00;
`endif
        return b;
    endfunction

    // Expected line level t edges after the trigger edge, from the frame
    // rule: each byte occupies P cycles, 3 idle-high then 10 bit slots.
    task automatic expect_at(input int t, output logic e_txd,
                             output logic e_busy, output logic e_done,
                             output int e_addr);
        int k, u, b;
        logic [7:0] byt;
        if (t < NPIX * P) begin
            k = t / P;
            u = t % P;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_addr = k;
            if (u < 3) begin
                e_txd = 1'b1;
            end else begin
                b = (u - 3) / CPB;
                byt = exp_byte(k);
                if (b == 0)      e_txd = 1'b0;
                else if (b == 9) e_txd = 1'b1;
                else             e_txd = byt[b-1];
            end
        end else begin
            e_txd  = 1'b1;
            e_busy = 1'b0;
            e_done = (t == NPIX * P);
            e_addr = NPIX - 1;
        end
    endtask

    // Caller arranges that the next clock edge is the trigger edge.
    task automatic check_frame(input bit toggle, input int abort_at);
        logic e_txd, e_busy, e_done;
        int   e_addr;
        for (int t = 0; t <= NPIX * P + 4; t++) begin
            @(posedge clk);
            #1;
            expect_at(t, e_txd, e_busy, e_done, e_addr);
            check("txd", 32'(txd), 32'(e_txd));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("addrb2", 32'(addrb2), 32'(e_addr));
            if (toggle && t == 60) start = 1'b0;
            if (toggle && t == 63) start = 1'b1;
            if (t == abort_at) begin
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check("abort_txd", 32'(txd), 32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_addr", 32'(addrb2), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                rst_n = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk);
                    #1;
                    check("post_abort_txd", 32'(txd), 32'd1);
                    check("post_abort_done", 32'(done), 32'd0);
                    check("post_abort_busy", 32'(busy), 32'd0);
                end
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        mem[$urandom_range(NPIX - 1, 0)] = TH;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'h10 + 8'(i);
        rst_n = 1'b1;
        start = 1'b0;
        idle_cycles(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(addrb2), 32'd0);
        rst_n = 1'b0;
        idle_cycles(6);

        // Known pattern with a mid-frame start toggle that must be ignored.
        start = 1'b1;
        check_frame(1'b1, -1);
        start = 1'b0;
        idle_cycles($urandom_range(6, 2));

        // Fresh rising edge after done: identical second frame.
        start = 1'b1;
        check_frame(1'b0, -1);
        start = 1'b0;
        idle_cycles(3);

        // Reset during byte 3 data bits, then restart from pixel 0.
        fill_random();
        start = 1'b1;
        check_frame(1'b0, 3 * P + 3 + CPB + 5);
        start = 1'b1;
        check_frame(1'b0, -1);
        start = 1'b0;
        idle_cycles(3);

        // start already high when reset releases.
        fill_random();
        rst_n = 1'b1;
        start = 1'b1;
        idle_cycles(2);
        rst_n = 1'b0;
        check_frame(1'b0, -1);
        start = 1'b0;

        for (int f = 0; f < 3; f++) begin
            idle_cycles($urandom_range(8, 1));
            fill_random();
            start = 1'b1;
            check_frame(f == 1, -1);
            start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule

// File: doc/result_uart_dump.md
Name: result_uart_dump

Overview:
- Downstream stage of the edge detector: waits for its `ready`, then reads the result BRAM (port B) sequentially.
- Reads pixel 0 .. H*V-1 in raster order and streams each byte out over UART TX, 8N1, LSB first.
- Gives the host the filtered image without a debugger.
- Sits between the result BRAM read port and the board TX pin.

Parameters:
- H, 500, image width in pixels (must match edge detector).
- V, 500, image height in pixels.
- AW, 18, BRAM address width; H*V must be <= 2**AW (250000 needs 18 bits).
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- THRESH, 8'd64, binarization threshold (used only with BINARIZE_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset (the name is historical; 1 = reset).
- start  input  1  level; connected to edge detector `ready`; the dump triggers on its rising edge.
- addrb2  output  AW  result BRAM read address.
- doutb2  input  8  result BRAM read data, valid one cycle after addrb2 (1-cycle latency, no output register).
- txd  output  1  UART serial out, idles high.
- busy  output  1  high from trigger until the final stop bit completes.
- done  output  1  one-cycle pulse after the final stop bit of pixel H*V-1.

Behaviour:
- Reset values: addrb2=0, txd=1, busy=0, done=0, state=IDLE, start_q=0, bit and baud counters=0.
- Reset is synchronous; asserting it mid-frame aborts on the next edge and txd returns high. The host must resync.
- start_q registers start every cycle.
- Trigger condition: start & ~start_q, in IDLE only. Rising edges while busy are ignored.
- State IDLE: on trigger, addrb2<=0, busy<=1, go to FETCH.
- State FETCH: one cycle, address presented. Go to WAIT.
- State WAIT: one cycle, absorbs BRAM latency. Go to LOAD.
- State LOAD: shreg<=doutb2 (or the binarized value), txd<=0, baud_cnt<=0. Go to START.
- Timing: txd first falls 3 edges after the trigger edge.
- State START: hold txd=0 for CLKS_PER_BIT cycles. Then txd<=shreg[0], bit_cnt<=0, go to DATA.
- State DATA: each bit is held CLKS_PER_BIT cycles. Shift right; after bit_cnt==7 completes, txd<=1 and go to STOP.
- State STOP: hold txd=1 for CLKS_PER_BIT cycles, then:
  - if addrb2 == H*V-1: busy<=0, done<=1, go to IDLE;
  - else: addrb2<=addrb2+1, go to FETCH.
- Inter-byte gap: the stop bit is effectively extended by 3 cycles (FETCH, WAIT, LOAD). Legal 8N1.
- Frame length: H*V*(10*CLKS_PER_BIT+3) cycles from trigger to done.
- baud_cnt counts 0..CLKS_PER_BIT-1; the bit period ends when baud_cnt==CLKS_PER_BIT-1.
- Counter widths: baud_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is 3 bits.
- addrb2 never exceeds H*V-1; there is no wrap.
- done is high for exactly one cycle.
- Re-trigger: start must fall and rise again (edge detector reset and rerun) to send a new frame.
- If start is already high when reset releases: start_q=0 at reset, so the first cycle after reset counts as a rising edge and the frame sends.

Optional Feature:
- Macro: BINARIZE_EN.
- Defined: LOAD captures (doutb2 >= THRESH) ? 8'hFF : 8'h00. The comparison is unsigned and the boundary value THRESH maps to FF.
- Undefined: the raw doutb2 byte is sent, and THRESH is unused.
- Timing is identical in both cases.

Decomposition:
- Package edge_pkg holds:
  - H, V, AW defaults shared with the edge detector;
  - state enum IDLE/FETCH/WAIT/LOAD/START/DATA/STOP;
  - localparam NPIX = H*V.
- Natural sub-module uart_tx_byte: owns START/DATA/STOP and the baud/bit counters.
  - Inputs: clk, rst_n, tx_valid, tx_data[7:0].
  - Outputs: tx_ready, txd.
  - result_uart_dump keeps IDLE/FETCH/WAIT/LOAD, addressing and done. tx_valid is pulsed from LOAD when tx_ready=1.

Test Plan:
- Bench setup: H=4, V=2, CLKS_PER_BIT=4; BRAM model preloaded mem[i]=8'h10+i.
- Basic frame: start 0->1 at cycle 10 -> txd low at cycle 13; bytes 10,11,...,17 decoded in order; done pulses once at 10 + 8*43 = cycle 354; busy low the same cycle.
- Bit timing: on the first byte 8'h10, each txd level is held exactly 4 cycles; sequence 0,0,0,0,0,1,0,0,0,1 (start, LSB-first data, stop).
- Ignored re-trigger: toggle start 1->0->1 mid-frame -> frame unaffected, still 8 bytes, one done. A fresh 0->1 after done -> second identical frame.
- Reset mid-frame: assert rst_n during byte 3 DATA -> next edge txd=1, busy=0, addrb2=0; no done. A later trigger restarts from pixel 0.
- BINARIZE_EN with THRESH=8'h13: bytes sent 00,00,00,FF,FF,FF,FF,FF (0x13 itself maps to FF).
- Start high out of reset: hold start=1 while releasing rst_n -> frame begins; txd low 3 cycles after the first post-reset edge.
